// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall controller: register scoreboard, branch-pending FSM with timeout,
// saturating stall-cycle counters and a sticky error flag. State advances on the falling clock edge.
module hazard_stall_ctrl #(
  parameter int NUM_REGS   = 16,
  parameter int REG_IDX_W  = 4,
  parameter int BR_TIMEOUT = 8,
  parameter int WB_BYPASS  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                 I_CLOCK,
  input  logic                 I_LOCK,
  input  logic                 I_DecValid,
  input  logic                 I_DecIsBranch,
  input  logic [REG_IDX_W-1:0] I_DecSrc1,
  input  logic                 I_DecSrc1Valid,
  input  logic [REG_IDX_W-1:0] I_DecSrc2,
  input  logic                 I_DecSrc2Valid,
  input  logic [REG_IDX_W-1:0] I_DecDest,
  input  logic                 I_DecDestValid,
  input  logic                 I_WbValid,
  input  logic [REG_IDX_W-1:0] I_WbDest,
  input  logic                 I_BranchResolve,
  output logic                 O_DepStallSignal,
  output logic                 O_BranchStallSignal,
  output logic                 O_Issue,
  output logic [CNT_W-1:0]     O_DepStallCount,
  output logic [CNT_W-1:0]     O_BrStallCount,
  output logic                 O_Error
);

  typedef enum logic [1:0] {IDLE, BR_PEND, BR_ERR} state_t;

  localparam int TO_W = $clog2(BR_TIMEOUT + 1);

  state_t              state;
  logic [TO_W-1:0]     to_cnt;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] eff;
  logic                hazard;
  logic                idle;

  always_comb begin
    wb_mask = '0;
    if (I_WbValid) wb_mask[I_WbDest] = 1'b1;
  end

  assign eff    = (WB_BYPASS != 0) ? (pending & ~wb_mask) : pending;
  assign hazard = I_DecValid & ((I_DecSrc1Valid & eff[I_DecSrc1]) |
                                (I_DecSrc2Valid & eff[I_DecSrc2]) |
                                (I_DecDestValid & eff[I_DecDest]));
  assign idle   = (state == IDLE);

  // Outputs are forced low while reset is held, even if decode presents a branch.
  assign O_DepStallSignal    = I_LOCK & hazard & idle;
  assign O_BranchStallSignal = I_LOCK & (~idle | (I_DecValid & I_DecIsBranch & ~hazard));
  assign O_Issue             = I_LOCK & I_DecValid & ~hazard & idle;

  always_comb begin
    set_mask = '0;
    if (O_Issue && I_DecDestValid) set_mask[I_DecDest] = 1'b1;
  end

  // Set is OR-ed in after the clear so a same-index set/clear leaves the bit pending.
  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~wb_mask) | set_mask;
    end
  end

  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      state   <= IDLE;
      to_cnt  <= '0;
      O_Error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I_BranchResolve) O_Error <= 1'b1;
          if (O_Issue && I_DecIsBranch) begin
            state  <= BR_PEND;
            to_cnt <= '0;
          end
        end
        BR_PEND: begin
          if (I_BranchResolve) begin
            state <= IDLE;
          end else if (to_cnt == TO_W'(BR_TIMEOUT - 1)) begin
            state   <= BR_ERR;
            O_Error <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        BR_ERR: state <= BR_ERR;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      O_DepStallCount <= '0;
      O_BrStallCount  <= '0;
    end else begin
      if (O_DepStallSignal && (O_DepStallCount != {CNT_W{1'b1}}))
        O_DepStallCount <= O_DepStallCount + 1'b1;
      if (O_BranchStallSignal && (O_BrStallCount != {CNT_W{1'b1}}))
        O_BrStallCount <= O_BrStallCount + 1'b1;
    end
  end

endmodule
